// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: memory-stage FSM states, word width and reset constants.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } memState_t;

  localparam int WORD_W = 32;

  localparam memState_t          RST_STATE = IDLE;
  localparam logic [WORD_W-1:0]  RST_WORD  = '0;
  localparam logic               RST_BIT   = 1'b0;

endpackage

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: req/ack data-memory access with front-end stall and MEM/WB bubble insertion.
// Optional misaligned-access trap enabled by defining MEM_ALIGN_CHECK_EN.
module mem_access_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              validIn,
  input  logic              memReadIn,
  input  logic              memWriteIn,
  input  logic [DATA_W-1:0] aluResultIn,
  input  logic [DATA_W-1:0] writeDataIn,
  input  logic [4:0]        rdIn,
  input  logic              memToRegIn,
  input  logic              regWriteIn,
  output logic              dmemReq,
  output logic              dmemWe,
  output logic [DATA_W-1:0] dmemAddr,
  output logic [DATA_W-1:0] dmemWdata,
  input  logic [DATA_W-1:0] dmemRdata,
  input  logic              dmemAck,
  output logic              memStall,
  output logic [DATA_W-1:0] memDataOut,
  output logic [DATA_W-1:0] aluDataOut,
  output logic [4:0]        rdOut,
  output logic              memToRegOut,
  output logic              regWriteOut,
  output logic              memMisaligned
);

  memState_t         state;
  logic [DATA_W-1:0] rdataQ;
  logic              misQ;
  logic              memOp;
  logic              misalign;

  assign memOp = validIn & (memReadIn | memWriteIn);

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = |aluResultIn[1:0];
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RST_STATE;
      dmemReq   <= RST_BIT;
      dmemWe    <= RST_BIT;
      dmemAddr  <= DATA_W'(RST_WORD);
      dmemWdata <= DATA_W'(RST_WORD);
      rdataQ    <= DATA_W'(RST_WORD);
      misQ      <= RST_BIT;
    end else begin
      case (state)
        IDLE: begin
          misQ <= 1'b0;
          if (memOp) begin
            // A misaligned access skips memory entirely and reports in DONE.
            if (misalign) begin
              misQ  <= 1'b1;
              state <= DONE;
            end else begin
              dmemAddr  <= aluResultIn;
              dmemWdata <= writeDataIn;
              dmemWe    <= memWriteIn;
              dmemReq   <= 1'b1;
              state     <= REQ;
            end
          end
        end
        REQ: begin
          if (dmemAck) begin
            if (!dmemWe) rdataQ <= dmemRdata;
            dmemReq <= 1'b0;
            state   <= DONE;
          end
        end
        DONE: begin
          misQ  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Gated by rst so an abandoned access releases the front end immediately.
  assign memStall = ~rst & (((state == IDLE) & memOp) | (state == REQ));

  always_comb begin
    memDataOut = '0;
    if ((state == DONE) && memReadIn && !misQ) memDataOut = rdataQ;
  end

  assign aluDataOut    = aluResultIn;
  assign rdOut         = rdIn;
  assign memToRegOut   = memToRegIn;
  assign regWriteOut   = regWriteIn & validIn & ~memStall & ~misQ;
  assign memMisaligned = misQ;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        validIn, memReadIn, memWriteIn, memToRegIn, regWriteIn;
  logic [31:0] aluResultIn, writeDataIn, dmemRdata;
  logic [4:0]  rdIn;
  logic        dmemAck;
  logic        dmemReq, dmemWe, memStall, memToRegOut, regWriteOut, memMisaligned;
  logic [31:0] dmemAddr, dmemWdata, memDataOut, aluDataOut;
  logic [4:0]  rdOut;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned stallCnt;
  int unsigned reqCnt;

  mem_access_stage #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .validIn(validIn), .memReadIn(memReadIn),
    .memWriteIn(memWriteIn), .aluResultIn(aluResultIn), .writeDataIn(writeDataIn),
    .rdIn(rdIn), .memToRegIn(memToRegIn), .regWriteIn(regWriteIn),
    .dmemReq(dmemReq), .dmemWe(dmemWe), .dmemAddr(dmemAddr), .dmemWdata(dmemWdata),
    .dmemRdata(dmemRdata), .dmemAck(dmemAck), .memStall(memStall),
    .memDataOut(memDataOut), .aluDataOut(aluDataOut), .rdOut(rdOut),
    .memToRegOut(memToRegOut), .regWriteOut(regWriteOut), .memMisaligned(memMisaligned)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic setInstr(input logic v, input logic rd, input logic wr, input logic [31:0] alu,
                          input logic [31:0] wd, input logic [4:0] rdn, input logic m2r,
                          input logic rw);
    validIn = v; memReadIn = rd; memWriteIn = wr; aluResultIn = alu;
    writeDataIn = wd; rdIn = rdn; memToRegIn = m2r; regWriteIn = rw;
  endtask

  initial begin
    rst = 1'b1; dmemAck = 1'b0; dmemRdata = '0;
    setInstr(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    #1;
    chk("rst_req",   32'(dmemReq), 32'd0);
    chk("rst_we",    32'(dmemWe), 32'd0);
    chk("rst_addr",  dmemAddr, 32'h0);
    chk("rst_wdata", dmemWdata, 32'h0);
    chk("rst_stall", 32'(memStall), 32'd0);
    chk("rst_mdata", memDataOut, 32'h0);
    chk("rst_mis",   32'(memMisaligned), 32'd0);
    cyc(); cyc();
    rst = 1'b0;

    // ALU instruction: pass-through, no stall
    setInstr(1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd5, 1'b0, 1'b1);
    #1;
    chk("alu_stall", 32'(memStall), 32'd0);
    chk("alu_rw",    32'(regWriteOut), 32'd1);
    chk("alu_rd",    32'(rdOut), 32'd5);
    chk("alu_data",  aluDataOut, 32'h1234);
    cyc();

    // Load 0x100, ack on first REQ cycle
    setInstr(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 5'd8, 1'b1, 1'b1);
    #1;
    chk("ld_idle_stall", 32'(memStall), 32'd1);
    chk("ld_idle_rw",    32'(regWriteOut), 32'd0);
    chk("ld_idle_req",   32'(dmemReq), 32'd0);
    cyc();
    chk("ld_req",       32'(dmemReq), 32'd1);
    chk("ld_addr",      dmemAddr, 32'h100);
    chk("ld_we",        32'(dmemWe), 32'd0);
    chk("ld_req_stall", 32'(memStall), 32'd1);
    dmemAck = 1'b1; dmemRdata = 32'hDEADBEEF;
    cyc();
    dmemAck = 1'b0; dmemRdata = 32'h0;
    chk("ld_done_req",   32'(dmemReq), 32'd0);
    chk("ld_done_stall", 32'(memStall), 32'd0);
    chk("ld_done_data",  memDataOut, 32'hDEADBEEF);
    chk("ld_done_rw",    32'(regWriteOut), 32'd1);
    chk("ld_done_m2r",   32'(memToRegOut), 32'd1);
    cyc();
    setInstr(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    #1;
    chk("ld_after_stall", 32'(memStall), 32'd0);
    chk("ld_after_data",  memDataOut, 32'h0);
    chk("ld_after_req",   32'(dmemReq), 32'd0);
    cyc();

    // Store 0x200, ack after 3 waiting REQ cycles
    setInstr(1'b1, 1'b0, 1'b1, 32'h200, 32'hA5A5A5A5, 5'd9, 1'b0, 1'b0);
    #1;
    stallCnt = 0;
    if (memStall) stallCnt++;
    chk("st_idle_rw", 32'(regWriteOut), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (memStall) stallCnt++;
      chk("st_req",   32'(dmemReq), 32'd1);
      chk("st_we",    32'(dmemWe), 32'd1);
      chk("st_addr",  dmemAddr, 32'h200);
      chk("st_wdata", dmemWdata, 32'hA5A5A5A5);
      chk("st_rw",    32'(regWriteOut), 32'd0);
      if (i == 3) dmemAck = 1'b1;
    end
    cyc();
    dmemAck = 1'b0;
    if (memStall) stallCnt++;
    chk("st_done_stall", 32'(memStall), 32'd0);
    chk("st_done_data",  memDataOut, 32'h0);
    chk("st_done_rw",    32'(regWriteOut), 32'd0);
    chk("st_done_req",   32'(dmemReq), 32'd0);
    chk("st_stall_cnt",  stallCnt, 32'd5);
    cyc();

    // Reset during the second REQ cycle abandons the access
    setInstr(1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 5'd10, 1'b1, 1'b1);
    cyc();
    chk("rr_req1", 32'(dmemReq), 32'd1);
    cyc();
    rst = 1'b1;
    #1;
    chk("rr_req_drop",  32'(dmemReq), 32'd0);
    chk("rr_stall_rel", 32'(memStall), 32'd0);
    setInstr(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    cyc();
    rst = 1'b0;
    dmemAck = 1'b1; dmemRdata = 32'h55555555;
    cyc();
    dmemAck = 1'b0;
    chk("stray_req",   32'(dmemReq), 32'd0);
    chk("stray_stall", 32'(memStall), 32'd0);
    chk("stray_data",  memDataOut, 32'h0);
    setInstr(1'b1, 1'b1, 1'b0, 32'h400, 32'h0, 5'd11, 1'b1, 1'b1);
    cyc();
    chk("rr_new_addr", dmemAddr, 32'h400);
    dmemAck = 1'b1; dmemRdata = 32'h11223344;
    cyc();
    dmemAck = 1'b0;
    chk("rr_new_data", memDataOut, 32'h11223344);
    chk("rr_new_rw",   32'(regWriteOut), 32'd1);
    cyc();

    // Back-to-back loads 0x10 / 0x14
    reqCnt = 0;
    setInstr(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 5'd12, 1'b1, 1'b1);
    #1;
    chk("bb1_stall", 32'(memStall), 32'd1);
    cyc();
    if (dmemReq) reqCnt++;
    chk("bb1_addr", dmemAddr, 32'h10);
    dmemAck = 1'b1; dmemRdata = 32'hAAAA0001;
    cyc();
    dmemAck = 1'b0;
    if (dmemReq) reqCnt++;
    chk("bb1_data", memDataOut, 32'hAAAA0001);
    cyc();
    setInstr(1'b1, 1'b1, 1'b0, 32'h14, 32'h0, 5'd13, 1'b1, 1'b1);
    #1;
    if (dmemReq) reqCnt++;
    chk("bb2_idle_stall", 32'(memStall), 32'd1);
    chk("bb2_idle_data",  memDataOut, 32'h0);
    cyc();
    if (dmemReq) reqCnt++;
    chk("bb2_addr", dmemAddr, 32'h14);
    dmemAck = 1'b1; dmemRdata = 32'hBBBB0002;
    cyc();
    dmemAck = 1'b0;
    if (dmemReq) reqCnt++;
    chk("bb2_data",   memDataOut, 32'hBBBB0002);
    chk("bb_req_cnt", reqCnt, 32'd2);
    cyc();

    // Misaligned load at 0x102
    setInstr(1'b1, 1'b1, 1'b0, 32'h102, 32'h0, 5'd14, 1'b1, 1'b1);
    #1;
    chk("mis_idle_stall", 32'(memStall), 32'd1);
`ifdef MEM_ALIGN_CHECK_EN
    cyc();
    chk("mis_req",   32'(dmemReq), 32'd0);
    chk("mis_flag",  32'(memMisaligned), 32'd1);
    chk("mis_rw",    32'(regWriteOut), 32'd0);
    chk("mis_data",  memDataOut, 32'h0);
    chk("mis_stall", 32'(memStall), 32'd0);
    cyc();
    setInstr(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    #1;
    chk("mis_flag_clr", 32'(memMisaligned), 32'd0);
`else
    cyc();
    chk("mis_req",  32'(dmemReq), 32'd1);
    chk("mis_addr", dmemAddr, 32'h102);
    chk("mis_flag", 32'(memMisaligned), 32'd0);
    dmemAck = 1'b1; dmemRdata = 32'hCAFE0102;
    cyc();
    dmemAck = 1'b0;
    chk("mis_data", memDataOut, 32'hCAFE0102);
    chk("mis_flag_done", 32'(memMisaligned), 32'd0);
`endif
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
